// File: rtl/arms_bus_pkg.sv
// Shared types and constants for the two-master Avalon memory arbiter.
package arms_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_WAIT_DEFAULT = 64;

endpackage

// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon RAM slave between a data master and an
// instruction master, with a sticky slave-stall timeout flag.
module avalon_mem_arbiter
    import arms_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    output logic [31:0] s_address,
    output logic [3:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic        timeout
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        last_d;
    logic [7:0]  wait_cnt;
    logic        d_req;
    logic        complete;

    assign d_req      = d_read | d_write;
    assign d_readdata = s_readdata;
    assign i_readdata = s_readdata;
    assign complete   = (state != IDLE) && (s_read || s_write) && !s_waitrequest;

    // Slave-side mux: only the granted master reaches the slave.
    always_comb begin
        s_address     = '0;
        s_byteenable  = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = '0;
        d_waitrequest = 1'b1;
        i_waitrequest = 1'b1;
        case (state)
            GRANT_D: begin
                s_address     = d_address;
                s_byteenable  = d_byteenable;
                s_write       = d_write;
                s_read        = d_read & ~d_write;
                s_writedata   = d_writedata;
                d_waitrequest = s_waitrequest;
            end
            GRANT_I: begin
                s_address     = i_address;
                s_byteenable  = 4'b1111;
                s_read        = i_read;
                i_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    // Grants always end in IDLE, which guarantees the one-cycle gap between transfers.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_req && i_read)
                    state_nxt = last_d ? GRANT_I : GRANT_D;
                else if (d_req)
                    state_nxt = GRANT_D;
                else if (i_read)
                    state_nxt = GRANT_I;
            end
            GRANT_D: if (complete || !d_req)  state_nxt = IDLE;
            GRANT_I: if (complete || !i_read) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (complete)
                last_d <= (state == GRANT_D);
            // IDLE precedes every grant, so clearing here clears on grant entry.
            if (state == IDLE)
                wait_cnt <= '0;
            else if (s_waitrequest && wait_cnt != MAX_WAIT_C)
                wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == MAX_WAIT_C)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: table-driven single transfers with a
// scoreboard, plus hand-written sequences for arbitration, hold-off, timeout and reset.
module tb_avalon_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d_address;
    logic [3:0]  d_byteenable;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] s_address;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        timeout;

    int checks = 0;
    int passes = 0;

    // Slave model: stalls each access for wait_n cycles, data derived from address.
    int wait_n   = 0;
    int busy_cnt = 0;
    assign s_waitrequest = (s_read | s_write) ? (busy_cnt < wait_n) : 1'b1;
    assign s_readdata    = s_address + 32'h1000_0000;

    always @(posedge clk) begin
        if ((s_read | s_write) && s_waitrequest) busy_cnt <= busy_cnt + 1;
        else                                     busy_cnt <= 0;
    end

    always #5 clk = ~clk;

    avalon_mem_arbiter #(.MAX_WAIT(64)) dut (
        .clk(clk), .reset(reset),
        .d_address(d_address), .d_byteenable(d_byteenable), .d_read(d_read),
        .d_write(d_write), .d_writedata(d_writedata), .d_waitrequest(d_waitrequest),
        .d_readdata(d_readdata),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
        .i_readdata(i_readdata),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
        .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .timeout(timeout)
    );

    typedef struct {
        bit          is_d;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        bit          e_rd;
        bit          e_wr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        bit          rd;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_address = '0; d_byteenable = '0; d_read = 0; d_write = 0; d_writedata = '0;
        i_address = '0; i_read = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_srw"},  {30'd0, s_read, s_write}, 32'd0);
        chk({name, "_saddr"}, s_address, 32'd0);
        chk({name, "_sbe"},   {28'd0, s_byteenable}, 32'd0);
        chk({name, "_swd"},   s_writedata, 32'd0);
        chk({name, "_waits"}, {30'd0, d_waitrequest, i_waitrequest}, 32'd3);
    endtask

    // Waits for the given master's waitrequest to drop; returns stalled cycles seen.
    task automatic wait_done(input bit is_d, input int bound, input string name,
                             output int w, output bit done);
        w = 0; done = 0;
        for (int k = 0; k < bound && !done; k++) begin
            @(posedge clk); #2;
            if ((is_d ? d_waitrequest : i_waitrequest) == 1'b0) done = 1;
            else w++;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s_bound: got no completion expected completion within %0d cycles", name, bound);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   w;
        bit   done;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wait_n = v.waits;
        d_address = v.addr; d_byteenable = v.be; d_writedata = v.wdata;
        i_address = v.addr;
        if (v.is_d) begin d_read = v.rd; d_write = v.wr; end
        else i_read = 1'b1;
        e.addr = v.e_addr; e.be = v.e_be; e.rd = v.e_rd; e.wr = v.e_wr;
        e.wdata = v.e_wdata; e.rdata = v.e_rdata;
        sb.push_back(e);
        #1;
        chk({nm, "_arb_idle"}, {30'd0, s_read, s_write}, 32'd0);
        wait_done(v.is_d, v.waits + 4, nm, w, done);
        if (done && sb.size() > 0) begin
            got = sb.pop_front();
            chk({nm, "_saddr"}, s_address, got.addr);
            chk({nm, "_sbe"},   {28'd0, s_byteenable}, {28'd0, got.be});
            chk({nm, "_srw"},   {30'd0, s_read, s_write}, {30'd0, got.rd, got.wr});
            chk({nm, "_swd"},   s_writedata, got.wdata);
            chk({nm, "_rdata"}, v.is_d ? d_readdata : i_readdata, got.rdata);
            chk({nm, "_other_wait"}, {31'd0, v.is_d ? i_waitrequest : d_waitrequest}, 32'd1);
            chk({nm, "_stalls"}, w, v.waits);
        end
        step();
        idle_inputs();
        #1;
        chk_idle({nm, "_after"});
    endtask

    vec_t vecs[6];
    int   w;
    bit   done;

    initial begin
        vecs[0] = '{1, 1, 0, 32'h0000_0010, 4'hF, 32'h1111_1111, 3,
                    32'h0000_0010, 4'hF, 1, 0, 32'h1111_1111, 32'h1000_0010};
        vecs[1] = '{1, 0, 1, 32'h0000_0020, 4'h3, 32'hDEAD_BEEF, 0,
                    32'h0000_0020, 4'h3, 0, 1, 32'hDEAD_BEEF, 32'h1000_0020};
        vecs[2] = '{1, 1, 1, 32'h0000_0024, 4'hC, 32'hCAFE_F00D, 1,
                    32'h0000_0024, 4'hC, 0, 1, 32'hCAFE_F00D, 32'h1000_0024};
        vecs[3] = '{0, 1, 0, 32'h0000_0040, 4'h2, 32'h5555_5555, 2,
                    32'h0000_0040, 4'hF, 1, 0, 32'h0000_0000, 32'h1000_0040};
        vecs[4] = '{0, 1, 0, 32'h0000_0080, 4'h0, 32'hAAAA_AAAA, 0,
                    32'h0000_0080, 4'hF, 1, 0, 32'h0000_0000, 32'h1000_0080};
        vecs[5] = '{1, 1, 0, 32'hFFFF_FFFC, 4'h1, 32'h0, 5,
                    32'hFFFF_FFFC, 4'h1, 1, 0, 32'h0000_0000, 32'h0FFF_FFFC};

        idle_inputs();
        do_reset();
        #1;
        chk_idle("reset");
        chk("reset_timeout", {31'd0, timeout}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Tie from reset: data first, then instruction, then data again; abort keeps pointer.
        do_reset();
        wait_n = 1;
        d_address = 32'h100; d_byteenable = 4'hF; d_writedata = 32'h1234_5678; d_write = 1;
        i_address = 32'h200; i_read = 1;
        #1;
        chk_idle("tie1_idle");
        step(); #1;
        chk("tie1_grant_d", {30'd0, s_read, s_write}, 32'd1);
        chk("tie1_addr", s_address, 32'h100);
        chk("tie1_iwait", {31'd0, i_waitrequest}, 32'd1);
        chk("tie1_dwait_stall", {31'd0, d_waitrequest}, 32'd1);
        step(); #1;
        chk("tie1_d_done", {31'd0, d_waitrequest}, 32'd0);
        step(); #1;
        chk_idle("tie1_gap");
        step(); #1;
        chk("tie2_grant_i", {30'd0, s_read, s_write}, 32'd2);
        chk("tie2_addr", s_address, 32'h200);
        chk("tie2_be", {28'd0, s_byteenable}, 32'hF);
        chk("tie2_dwait", {31'd0, d_waitrequest}, 32'd1);
        step(); #1;
        chk("tie2_i_done", {31'd0, i_waitrequest}, 32'd0);
        chk("tie2_rdata", i_readdata, 32'h1000_0200);
        step(); #1;
        chk_idle("tie2_gap");
        step(); #1;
        chk("tie3_grant_d", {30'd0, s_read, s_write}, 32'd1);
        chk("tie3_addr", s_address, 32'h100);
        d_write = 0; i_read = 0;
        step(); #1;
        chk_idle("abort_idle");
        d_write = 1; i_read = 1;
        step(); #1;
        chk("abort_keeps_ptr", s_address, 32'h100);
        chk("abort_keeps_ptr_w", {30'd0, s_read, s_write}, 32'd1);
        wait_done(1'b1, 5, "tie4", w, done);
        step();
        idle_inputs();

        // Data write arriving during an instruction grant is held off, then forwarded intact.
        wait_n = 4;
        i_address = 32'h40; i_read = 1;
        step(); #1;
        chk("hold_grant_i", {30'd0, s_read, s_write}, 32'd2);
        d_address = 32'h300; d_byteenable = 4'b0011; d_writedata = 32'hDEAD_BEEF; d_write = 1;
        #1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            chk("hold_swrite", {31'd0, s_write}, 32'd0);
            chk("hold_dwait", {31'd0, d_waitrequest}, 32'd1);
            if (i_waitrequest == 1'b0) done = 1;
            else begin step(); #1; end
        end
        chk("hold_i_done", {31'd0, done}, 32'd1);
        chk("hold_i_rdata", i_readdata, 32'h1000_0040);
        step();
        i_read = 0;
        #1;
        chk_idle("hold_gap");
        step(); #1;
        chk("hold_fwd_write", {30'd0, s_read, s_write}, 32'd1);
        chk("hold_fwd_addr", s_address, 32'h300);
        chk("hold_fwd_be", {28'd0, s_byteenable}, 32'h3);
        chk("hold_fwd_wd", s_writedata, 32'hDEAD_BEEF);
        wait_done(1'b1, 8, "hold_w", w, done);
        step();
        idle_inputs();

        // Slave stalls 70 cycles: timeout rises, transfer still completes, flag is sticky.
        wait_n = 70;
        d_address = 32'h500; d_byteenable = 4'hF; d_read = 1;
        step(); #1;
        for (int g = 1; g < 71; g++) begin
            if (g == 1)  chk("to_g1", {31'd0, timeout}, 32'd0);
            if (g == 64) chk("to_g64", {31'd0, timeout}, 32'd0);
            if (g == 66) chk("to_g66", {31'd0, timeout}, 32'd1);
            chk_stall: if (d_waitrequest !== 1'b1) begin
                checks++;
                $display("FAIL to_stall: got waitrequest %b at grant cycle %0d expected 1", d_waitrequest, g);
            end
            step(); #1;
        end
        chk("to_complete", {31'd0, d_waitrequest}, 32'd0);
        chk("to_rdata", d_readdata, 32'h1000_0500);
        chk("to_at_done", {31'd0, timeout}, 32'd1);
        step();
        idle_inputs();
        step(); step(); #1;
        chk("to_sticky", {31'd0, timeout}, 32'd1);
        do_reset();
        #1;
        chk("to_cleared", {31'd0, timeout}, 32'd0);

        // Reset mid-grant: slave drops, pointer back to data.
        wait_n = 0;
        d_address = 32'h600; d_byteenable = 4'hF; d_read = 1;
        step(); #1;
        chk("rst_pre_done", {31'd0, d_waitrequest}, 32'd0);
        step();
        wait_n = 1000;
        #1;
        chk_idle("rst_pre_gap");
        step(); #1;
        chk("rst_granted", {30'd0, s_read, s_write}, 32'd2);
        reset = 1;
        step();
        reset = 0;
        i_address = 32'h700; i_read = 1;
        #1;
        chk_idle("rst_after");
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        step(); #1;
        chk("rst_tie_data", s_address, 32'h600);
        chk("rst_tie_iwait", {31'd0, i_waitrequest}, 32'd1);
        idle_inputs();
        wait_n = 0;
        step(); step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no end expected end before 200000");
        $fatal(1, "time limit");
    end

endmodule
